// File: rtl/timer_display_driver_pkg.sv
// Shared types and constants for the timer display driver: conversion FSM states,
// active-low 7-segment codes and the digit encoder.
package timer_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } conv_state_e;

  localparam int unsigned IdxW = 2;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/timer_display_driver_bin2bcd_serial.sv
// Serial 8-bit binary to 3-digit BCD converter (shift-add-3), one bit per clock.
// A start pulse loads the operand; the result is stable 8 clocks later.
module bin2bcd_serial
  import timer_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        over99
);

  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [3:0]  step_q;
  logic        over99_q;
  logic [11:0] adj;
  logic [19:0] shifted;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj, bin_q} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      step_q   <= 4'd8;
      over99_q <= 1'b0;
    end else if (start) begin
      bin_q    <= bin;
      bcd_q    <= '0;
      step_q   <= '0;
      over99_q <= (bin > 8'd99);
    end else if (step_q != 4'd8) begin
      bcd_q  <= shifted[19:8];
      bin_q  <= shifted[7:0];
      step_q <= step_q + 4'd1;
    end
  end

  assign bcd    = bcd_q;
  assign over99 = over99_q;

endmodule

// File: rtl/timer_display_driver.sv
// Display stage for the timer core: converts the two binary time fields to BCD
// and scans them onto a 4-digit multiplexed common-anode 7-segment display.
module timer_display_driver
  import timer_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1,
  parameter bit          LEAD_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] msb_bin,
  input  logic [7:0] lsb_bin,
  output logic       busy,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  conv_state_e state_q;
  logic [2:0]  cnt_q;
  logic        valid_q;
  logic [7:0]  msb_cap_q, lsb_cap_q;
  logic [3:0]  msb_tens_q, msb_ones_q, lsb_tens_q, lsb_ones_q;
  logic        msb_err_q, lsb_err_q;
  logic        start;

  logic [11:0] msb_bcd, lsb_bcd;
  logic        msb_over, lsb_over;

  logic [DivW-1:0] div_q;
  logic [IdxW-1:0] idx_q;
  logic [6:0]      seg_d;
  logic [3:0]      an_d;
  logic            dp_d;

  // The converters load straight from the inputs on the capture edge.
  assign start = (state_q == StIdle) &&
                 (!valid_q || ({msb_bin, lsb_bin} != {msb_cap_q, lsb_cap_q}));

  bin2bcd_serial u_msb_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin    (msb_bin),
    .bcd    (msb_bcd),
    .over99 (msb_over)
  );

  bin2bcd_serial u_lsb_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin    (lsb_bin),
    .bcd    (lsb_bcd),
    .over99 (lsb_over)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      msb_cap_q  <= '0;
      lsb_cap_q  <= '0;
      busy       <= 1'b0;
      msb_tens_q <= '0;
      msb_ones_q <= '0;
      lsb_tens_q <= '0;
      lsb_ones_q <= '0;
      msb_err_q  <= 1'b0;
      lsb_err_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            msb_cap_q <= msb_bin;
            lsb_cap_q <= lsb_bin;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (cnt_q == 3'd7) begin
            state_q <= StCommit;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StCommit: begin
          msb_tens_q <= msb_bcd[7:4];
          msb_ones_q <= msb_bcd[3:0];
          lsb_tens_q <= lsb_bcd[7:4];
          lsb_ones_q <= lsb_bcd[3:0];
          msb_err_q  <= msb_over || (msb_bcd[11:8] != 4'd0);
          lsb_err_q  <= lsb_over || (lsb_bcd[11:8] != 4'd0);
          valid_q    <= 1'b1;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 4'hF;
    dp_d  = 1'b1;
    unique case (idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = lsb_err_q ? SEG_DASH : seg_encode(lsb_ones_q);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = lsb_err_q ? SEG_DASH : seg_encode(lsb_tens_q);
      end
      2'd2: begin
        an_d  = 4'b1011;
        dp_d  = 1'b0;
        seg_d = msb_err_q ? SEG_DASH : seg_encode(msb_ones_q);
      end
      2'd3: begin
        an_d = 4'b0111;
        if (msb_err_q) begin
          seg_d = SEG_DASH;
        end else if (LEAD_BLANK && (msb_tens_q == 4'd0)) begin
          seg_d = SEG_BLANK;
        end else begin
          seg_d = seg_encode(msb_tens_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      seg_n <= SEG_BLANK;
      an_n  <= 4'hF;
      dp_n  <= 1'b1;
    end else begin
      if (div_q == DivW'(SCAN_DIV - 1)) begin
        div_q <= '0;
        idx_q <= idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      seg_n <= seg_d;
      an_n  <= an_d;
      dp_n  <= dp_d;
    end
  end

endmodule

// File: tb/tb_timer_display_driver.sv
// Directed self-checking bench for timer_display_driver (SCAN_DIV=1, LEAD_BLANK=1).
module tb_timer_display_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] msb_bin = 8'd12;
  logic [7:0] lsb_bin = 8'd34;
  logic       busy;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'h7F;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_display_driver #(
    .SCAN_DIV   (1),
    .LEAD_BLANK (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .msb_bin (msb_bin),
    .lsb_bin (lsb_bin),
    .busy    (busy),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .an_n    (an_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge just after inputs change (or reset release); counts busy-high cycles.
  task automatic wait_busy(input string tag, input bit from_reset);
    int n;
    n = 0;
    @(negedge clk);
    if (from_reset) check({tag, "_scan0"}, an_n, 4'b1110);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy"}, n, 9);
  endtask

  // One full scan; every slot is checked against the digit that an_n selects.
  task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [3:0] seen;
    seen = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      case (an_n)
        4'b1110: begin
          check({tag, "_d0"}, seg_n, e0); check({tag, "_dp0"}, dp_n, 1'b1); seen[0] = 1'b1;
        end
        4'b1101: begin
          check({tag, "_d1"}, seg_n, e1); check({tag, "_dp1"}, dp_n, 1'b1); seen[1] = 1'b1;
        end
        4'b1011: begin
          check({tag, "_d2"}, seg_n, e2); check({tag, "_dp2"}, dp_n, 1'b0); seen[2] = 1'b1;
        end
        4'b0111: begin
          check({tag, "_d3"}, seg_n, e3); check({tag, "_dp3"}, dp_n, 1'b1); seen[3] = 1'b1;
        end
        default: check({tag, "_an"}, an_n, 4'b1110);
      endcase
    end
    check({tag, "_slots"}, seen, 4'hF);
  endtask

  initial begin
    int c0;
    int k;

    // Held in reset: everything dark and idle, even as inputs move.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_hold", {seg_n, an_n, dp_n, busy}, {SB, 4'hF, 1'b1, 1'b0});
      msb_bin = 8'(12 + (i % 2));
    end
    msb_bin = 8'd12;
    lsb_bin = 8'd34;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_busy0", busy, 1'b0);

    wait_busy("t2", 1'b1);
    scan_check("t2", S4, S3, S2, S1);

    msb_bin = 8'd5;
    lsb_bin = 8'd9;
    wait_busy("t3", 1'b0);
    scan_check("t3", S9, S0, S5, SB);

    msb_bin = 8'd7;
    lsb_bin = 8'd150;
    wait_busy("t4", 1'b0);
    scan_check("t4", SD, SD, S7, SB);

    msb_bin = 8'd200;
    lsb_bin = 8'd99;
    wait_busy("t4b", 1'b0);
    scan_check("t4b", S9, S9, SD, SD);

    // Mid-conversion input change is deferred to a second conversion.
    msb_bin = 8'd12;
    lsb_bin = 8'd34;
    @(negedge clk);
    c0 = cyc;
    check("t5_busy_up", busy, 1'b1);
    @(negedge clk);
    @(negedge clk);
    lsb_bin = 8'd56;
    k = 0;
    while (busy && k < 40) begin
      k++;
      @(negedge clk);
    end
    check("t5_first_done", cyc - c0, 9);
    scan_check("t5a", S4, S3, S2, S1);
    check("t5_second_busy", busy, 1'b1);
    k = 0;
    while (busy && k < 40) begin
      k++;
      @(negedge clk);
    end
    check("t5_second_done", cyc - c0, 19);
    scan_check("t5b", S6, S5, S2, S1);

    // Reset mid-conversion while the scan index sits at 2.
    msb_bin = 8'd34;
    lsb_bin = 8'd12;
    @(negedge clk);
    k = 0;
    while (an_n != 4'b1101 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("t6_idx2", an_n, 4'b1101);
    check("t6_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1 check("t6_async", {seg_n, an_n, dp_n, busy}, {SB, 4'hF, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    check("t6_hold", {seg_n, an_n, dp_n, busy}, {SB, 4'hF, 1'b1, 1'b0});
    rst_n = 1'b1;
    wait_busy("t6", 1'b1);
    scan_check("t6", S2, S1, S4, S3);

    // Unchanged inputs must not retrigger a conversion.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t7_stable", busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
